// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin FIFO write-port arbiter; burst locking enabled by FIFO_WR_ARB_BURST_EN
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      wclk,
    input  logic                      wrst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DATA_SIZE-1:0] req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      wfull,
    output logic                      winc,
    output logic [DATA_SIZE-1:0]      wdata,
    output logic [NREQ-1:0]           grant,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int ID_W = $clog2(NREQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    logic [ID_W-1:0] rr_ptr;
    logic            locked;
    logic [ID_W-1:0] owner;
    logic [BC_W-1:0] beat_cnt;

    logic [ID_W-1:0] sel;
    logic            has_sel;
    logic            xfer;
    logic            burst_continue;
    logic [ID_W-1:0] rr_next;
    int              idx;

    // Pick the requester: the lock owner if a burst is in progress, else the
    // first valid requester in circular order starting at rr_ptr.
    always_comb begin
        has_sel = 1'b0;
        sel     = '0;
        idx     = 0;
        if (locked) begin
            has_sel = 1'b1;
            sel     = owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (!has_sel && req_valid[idx]) begin
                    has_sel = 1'b1;
                    sel     = ID_W'(idx);
                end
            end
        end
    end

    // Drive the write port and handshake; everything is held at zero while reset is asserted.
    always_comb begin
        xfer      = wrst_n & has_sel & req_valid[sel] & ~wfull;
        winc      = xfer;
        req_ready = '0;
        grant     = '0;
        grant_id  = '0;
        wdata     = '0;
        busy      = locked & wrst_n;
        if (xfer) begin
            req_ready[sel] = 1'b1;
        end
        if (wrst_n && has_sel) begin
            grant[sel] = 1'b1;
            grant_id   = sel;
            wdata      = req_data[int'(sel)*DATA_SIZE +: DATA_SIZE];
        end
    end

`ifdef FIFO_WR_ARB_BURST_EN
    // Keep the grant while the owner has not signalled last and has beats left.
    always_comb begin
        burst_continue = !req_last[sel] && ((int'(beat_cnt) + 1) < MAX_BURST);
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;

    // Without bursting every word releases the grant.
    always_comb begin
        burst_continue = 1'b0;
    end
`endif

    // Explicit wrap so non-power-of-two requester counts rotate correctly.
    always_comb begin
        rr_next = (sel == ID_W'(NREQ - 1)) ? '0 : sel + 1'b1;
    end

    // Arbitration state advances only on a completed transfer.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rr_ptr   <= '0;
            locked   <= 1'b0;
            owner    <= '0;
            beat_cnt <= '0;
        end else if (xfer) begin
            if (burst_continue) begin
                locked   <= 1'b1;
                owner    <= sel;
                beat_cnt <= beat_cnt + 1'b1;
            end else begin
                locked   <= 1'b0;
                beat_cnt <= '0;
                rr_ptr   <= rr_next;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              wclk = 1'b0;
    logic              wrst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_last = '0;
    logic [N-1:0]      req_ready;
    logic              wfull = 1'b0;
    logic              winc;
    logic [DW-1:0]     wdata;
    logic [N-1:0]      grant;
    logic [1:0]        grant_id;
    logic              busy;

    fifo_wr_arbiter #(.NREQ(N), .DATA_SIZE(DW), .MAX_BURST(MB)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [DW-1:0] exp_q [N][$];
    logic [N-1:0] taken = '0;
    logic [N-1:0] offer_mask = '0;
    int           offer_pct = 0;
    int           full_pct = 0;

    // reference arbitration state: who won last, and beats granted in the current hold
    int last_win = N - 1;
    int owner_m  = 0;
    int beats    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // requesters: retire accepted words, offer new ones, randomize FIFO full
    initial begin
        logic [DW-1:0] w;
        forever begin
            @(negedge wclk);
            for (int i = 0; i < N; i++) begin
                if (taken[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && offer_mask[i] && ($urandom_range(99) < offer_pct)) begin
                    w = DW'($urandom_range(255));
                    req_data[i*DW +: DW] = w;
                    req_last[i] = ($urandom_range(99) < 30);
                    req_valid[i] = 1'b1;
                    exp_q[i].push_back(w);
                end
            end
            wfull = ($urandom_range(99) < full_pct);
        end
    end

    // monitor: compare DUT outputs against the reference just before each edge
    initial begin
        int pick;
        bit exp_xfer;
        forever begin
            @(negedge wclk);
            #4;
            if (!wrst_n) begin
                chk("reset_outputs", 32'({winc, req_ready, grant, grant_id, wdata, busy}), 32'd0);
                last_win = N - 1;
                beats    = 0;
                taken    = '0;
            end else begin
                pick = -1;
                if (beats > 0) begin
                    pick = owner_m;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        if (pick < 0 && req_valid[(last_win + k) % N]) pick = (last_win + k) % N;
                    end
                end
                exp_xfer = (pick >= 0) && req_valid[pick] && !wfull;
                chk("winc", 32'(winc), 32'(exp_xfer));
                chk("grant", 32'(grant), (pick >= 0) ? (32'd1 << pick) : 32'd0);
                chk("grant_id", 32'(grant_id), (pick >= 0) ? 32'(pick) : 32'd0);
                chk("req_ready", 32'(req_ready), exp_xfer ? (32'd1 << pick) : 32'd0);
                chk("busy", 32'(busy), 32'(beats > 0));
                taken = req_ready;
                if (exp_xfer) begin
                    if (exp_q[pick].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL scoreboard: requester %0d written with no word outstanding", pick);
                    end else begin
                        chk("wdata", 32'(wdata), 32'(exp_q[pick].pop_front()));
                    end
                    beats++;
`ifdef FIFO_WR_ARB_BURST_EN
                    if (!req_last[pick] && beats < MB) begin
                        owner_m = pick;
                    end else begin
                        beats    = 0;
                        last_win = pick;
                    end
`else
                    beats    = 0;
                    last_win = pick;
`endif
                end
            end
        end
    end

    initial begin
        offer_mask = 4'hF;
        offer_pct  = 100;
        full_pct   = 0;
        #1;
        chk("reset_initial", 32'({winc, req_ready, grant, grant_id, wdata, busy}), 32'd0);
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        #2 wrst_n = 1'b1;

        // all four requesters streaming, FIFO never full
        repeat (12) @(posedge wclk);

        // drain, then only requesters 0 and 2 with FIFO full for 3 cycles
        offer_mask = '0;
        repeat (8) @(posedge wclk);
        offer_mask = 4'b0101;
        full_pct   = 100;
        repeat (3) @(posedge wclk);
        full_pct   = 0;
        repeat (6) @(posedge wclk);

        // randomized traffic with random backpressure
        offer_mask = 4'hF;
        offer_pct  = 50;
        full_pct   = 25;
        repeat (400) @(posedge wclk);

        // asynchronous reset in the middle of busy traffic
        offer_pct = 100;
        full_pct  = 0;
        repeat (6) @(posedge wclk);
        @(negedge wclk);
        #2 wrst_n = 1'b0;
        #1 chk("async_reset", 32'({winc, req_ready, grant, grant_id, wdata, busy}), 32'd0);
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        #2 wrst_n = 1'b1;
        repeat (8) @(posedge wclk);

        offer_pct = 40;
        full_pct  = 30;
        repeat (200) @(posedge wclk);

        // drain: every offered word must eventually be written
        offer_mask = '0;
        full_pct   = 0;
        repeat (30) @(posedge wclk);
        @(negedge wclk);
        #4;
        chk("drain_valid", 32'(req_valid), 32'd0);
        for (int i = 0; i < N; i++) chk("drain_queue", 32'(exp_q[i].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the async FIFO write domain. It shares the single FIFO write port among `NREQ` requesters, each using a valid/ready handshake. It drives the write enable (`winc`) and the write data (`wdata`) consumed by the write-pointer logic and the dual-port memory, and backpressures every requester while `wfull` is high. It sits entirely in the `wclk` domain, ahead of the write-pointer/full-flag block.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `DATA_SIZE`, default 8: width of the FIFO data word.
- `MAX_BURST`, default 4: maximum beats per grant when bursting is compiled in; must be ≥1.
- `wclk`  in  1: write-domain clock, all state on posedge.
- `wrst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: requester i has a word on offer.
- `req_data`  in  NREQ*DATA_SIZE: packed words; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- `req_last`  in  NREQ: the offered word ends requester i's burst.
- `req_ready`  out  NREQ: requester i's word is accepted this cycle.
- `wfull`  in  1: FIFO full, from the write-pointer logic.
- `winc`  out  1: write-enable strobe to the pointer logic and the memory.
- `wdata`  out  DATA_SIZE: data of the selected requester.
- `grant`  out  NREQ: one-hot selected requester; all zero when none is selected.
- `grant_id`  out  $clog2(NREQ): index of the selected requester; 0 when none.
- `busy`  out  1: a burst lock is held.

## Operation
- State registers:
  - `rr_ptr`: round-robin start index, reset 0.
  - `locked`: reset 0.
  - `owner`: reset 0.
  - `beat_cnt`: width $clog2(MAX_BURST+1), reset 0.
- Selection (`sel`), combinational:
  - If `locked`, `sel` = `owner`, whether or not the owner's `req_valid` is high.
  - Otherwise, `sel` = the first i with `req_valid[i]`=1, searching `rr_ptr`, `rr_ptr`+1, … and wrapping modulo NREQ.
  - Otherwise (not locked, no valid), there is no selection.
- Transfer: `xfer` = selection exists & `req_valid[sel]` & !`wfull`.
- Outputs:
  - `winc` = `xfer`.
  - `req_ready[sel]` = `xfer`; every other `req_ready` bit is 0.
  - `wdata` = `req_data` slice of `sel`; 0 when there is no selection.
- Next state on `xfer` (burst mode):
  - If !`req_last[sel]` and `beat_cnt`+1 < MAX_BURST: `locked`←1, `owner`←`sel`, `beat_cnt`←`beat_cnt`+1.
  - Otherwise: `locked`←0, `beat_cnt`←0, `rr_ptr`←(`sel`+1) mod NREQ.
- Locked and the owner deasserts `req_valid`: the lock is held, there is no transfer, and other requesters stay blocked.
- `wfull`=1: no transfer, all `req_ready`=0, `winc`=0. Lock, `owner`, `beat_cnt` and `rr_ptr` are unchanged. `grant` still shows `sel`.
- No valid and not locked: state is unchanged.
- `busy` = `locked`.
- NREQ not a power of two: `rr_ptr` wrap is explicit, from NREQ-1 to 0.

## Timing
- Zero-cycle arbitration. A word offered in cycle N with `wfull`=0 is written at the `wclk` edge ending cycle N (`winc` and `wdata` are combinational).
- Sustained throughput is one word per cycle while the FIFO is not full.
- `rr_ptr`, `locked`, `owner` and `beat_cnt` update on the posedge that ends a transfer cycle.
- Reset:
  - While `wrst_n`=0, all registers clear asynchronously.
  - While `wrst_n`=0, `winc`, `req_ready`, `grant`, `grant_id`, `wdata` and `busy` are forced to 0, independent of inputs.
- Reset asserted mid-burst drops the lock immediately. The requester must re-offer the unaccepted word after reset.
- Requester rules:
  - `req_valid` must stay high and `req_data`/`req_last` stable until `req_ready`=1.
  - The arbiter does not check this.

## Configuration
- `FIFO_WR_ARB_BURST_EN` defined: burst locking is as described above, with up to MAX_BURST beats per grant, ended early by `req_last`.
- `FIFO_WR_ARB_BURST_EN` undefined:
  - Every transfer takes the "otherwise" branch, so `locked` stays 0 and `busy`=0.
  - `req_last` and MAX_BURST are ignored.
  - Grant rotates after every word.

## Test plan
- Reset, then `req_valid`=4'b1111 with `wfull`=0, burst disabled → grants in order 0,1,2,3,0; `winc`=1 every cycle; `wdata` matches each requester's word.
- Burst enabled, MAX_BURST=4, requester 1 offers 6 words with `req_last`=0 and requester 2 is valid → beats 1,1,1,1 then 2; `busy`=1 for exactly the cycles after beats 1, 2 and 3.
- Burst enabled, requester 0 offers `req_last`=1 on its 2nd word, requester 3 is valid → sequence 0,0,3; `rr_ptr`=1 after the 3rd word.
- `wfull` held at 1 for 3 cycles with requesters 0 and 2 valid → `winc`=0 and `req_ready`=0 throughout; after release, requester 0 is granted first and `rr_ptr` was not advanced.
- Locked to requester 2, which drops `req_valid` for 2 cycles while requester 0 is valid → no writes and `grant`=4'b0100; when requester 2 resumes, its burst continues.
- Assert `wrst_n`=0 mid-burst with `req_valid`=4'b1111 → all outputs 0 asynchronously; after release the first grant goes to requester 0 and `busy`=0.
